// File: rtl/cpu_pkg.sv
// Shared CPU types: condition codes, flag bit positions, ALU selects and the
// decode->execute control word carried by the E pipeline register.
package cpu_pkg;

    typedef enum logic [3:0] {
        EQ = 4'b0000, NE, CS, CC, MI, PL, VS, VC,
        HI, LS, GE, LT, GT, LE, AL, NV
    } cond_t;

    localparam int N = 3;
    localparam int Z = 2;
    localparam int C = 1;
    localparam int V = 0;

    localparam logic [2:0] ADD = 3'b000;
    localparam logic [2:0] SUB = 3'b001;
    localparam logic [2:0] AND = 3'b010;
    localparam logic [2:0] ORR = 3'b011;
    localparam logic [2:0] MOV = 3'b100;

    typedef struct packed {
        logic       pcs;
        logic       regw;
        logic       memtoreg;
        logic       memw;
        logic       alusrc;
        logic [2:0] alucontrol;
        logic [1:0] flagw;
        cond_t      cond;
        logic [3:0] wa3;
    } ectl_t;

    // A bubble carries AL so it reads as "passes" but every write control is off.
    localparam ectl_t BUBBLE = '{
        pcs:        1'b0,
        regw:       1'b0,
        memtoreg:   1'b0,
        memw:       1'b0,
        alusrc:     1'b0,
        alucontrol: ADD,
        flagw:      2'b00,
        cond:       AL,
        wa3:        4'd0
    };

endpackage

// File: rtl/cond_check.sv
// Combinational condition-code evaluator: does CondE pass against NZCV Flags.
module cond_check
    import cpu_pkg::*;
(
    input  logic [3:0] CondE,
    input  logic [3:0] Flags,
    output logic       CondExE
);

    logic n, z, c, v, ge;

    assign n  = Flags[N];
    assign z  = Flags[Z];
    assign c  = Flags[C];
    assign v  = Flags[V];
    assign ge = (n == v);

    always_comb begin
        CondExE = 1'b0;
        case (cond_t'(CondE))
            EQ: CondExE = z;
            NE: CondExE = ~z;
            CS: CondExE = c;
            CC: CondExE = ~c;
            MI: CondExE = n;
            PL: CondExE = ~n;
            VS: CondExE = v;
            VC: CondExE = ~v;
            HI: CondExE = c & ~z;
            LS: CondExE = ~c | z;
            GE: CondExE = ge;
            LT: CondExE = ~ge;
            GT: CondExE = ~z & ge;
            LE: CondExE = z | ~ge;
            AL: CondExE = 1'b1;
            NV: CondExE = 1'b0;
            default: CondExE = 1'b0;
        endcase
    end

endmodule

// File: rtl/idex_cond_stage.sv
// Decode->execute pipeline register with the NZCV flags register and
// conditional gating of write-type controls for failed conditions.
module idex_cond_stage
    import cpu_pkg::*;
#(
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       StallE,
    input  logic       FlushE,
    input  logic [3:0] CondD,
    input  logic [3:0] WA3D,
    input  logic       PCSD,
    input  logic       RegWD,
    input  logic       MemtoRegD,
    input  logic       MemWD,
    input  logic       ALUSrcD,
    input  logic [2:0] ALUControlD,
    input  logic [1:0] FlagWD,
    input  logic [3:0] ALUFlags,
    output logic       PCSrcE,
    output logic       RegWriteE,
    output logic       MemWriteE,
    output logic       MemtoRegE,
    output logic       ALUSrcE,
    output logic [2:0] ALUControlE,
    output logic [3:0] WA3E,
    output logic       CondExE,
    output logic [3:0] FlagsE
);

    ectl_t      d, e;
    logic [3:0] flags;
    logic       condex;

    always_comb begin
        d            = BUBBLE;
        d.pcs        = PCSD;
        d.regw       = RegWD;
        d.memtoreg   = MemtoRegD;
        d.memw       = MemWD;
        d.alusrc     = ALUSrcD;
        d.alucontrol = ALUControlD;
        d.flagw      = FlagWD;
        d.cond       = cond_t'(CondD);
        d.wa3        = WA3D;
    end

    always_ff @(posedge clk) begin
        if (reset)        e <= BUBBLE;
        else if (FlushE)  e <= BUBBLE;
        else if (!StallE) e <= d;
    end

    // Flush does not suppress the retiring instruction's flag write; stall does.
    always_ff @(posedge clk) begin
        if (reset) begin
            flags <= RESET_FLAGS;
        end else if (!StallE) begin
            if (e.flagw[1] && condex) flags[3:2] <= ALUFlags[3:2];
            if (e.flagw[0] && condex) flags[1:0] <= ALUFlags[1:0];
        end
    end

    cond_check u_cond (
        .CondE   (e.cond),
        .Flags   (flags),
        .CondExE (condex)
    );

    assign PCSrcE      = e.pcs  & condex;
    assign RegWriteE   = e.regw & condex;
    assign MemWriteE   = e.memw & condex;
    assign MemtoRegE   = e.memtoreg;
    assign ALUSrcE     = e.alusrc;
    assign ALUControlE = e.alucontrol;
    assign WA3E        = e.wa3;
    assign CondExE     = condex;
    assign FlagsE      = flags;

endmodule

// File: tb/tb_idex_cond_stage.sv
// Scoreboard bench for idex_cond_stage: the driver queues hand-computed
// expected E outputs per cycle, a negedge monitor pops and compares them.
module tb_idex_cond_stage;

    logic       clk, reset, StallE, FlushE;
    logic [3:0] CondD, WA3D, ALUFlags;
    logic       PCSD, RegWD, MemtoRegD, MemWD, ALUSrcD;
    logic [2:0] ALUControlD;
    logic [1:0] FlagWD;
    logic       PCSrcE, RegWriteE, MemWriteE, MemtoRegE, ALUSrcE, CondExE;
    logic [2:0] ALUControlE;
    logic [3:0] WA3E, FlagsE;

    localparam logic [3:0] C_EQ = 4'h0, C_NE = 4'h1, C_LT = 4'hB, C_GT = 4'hC;
    localparam logic [3:0] C_LE = 4'hD, C_AL = 4'hE, C_NV = 4'hF;

    typedef struct packed {
        logic [3:0] cond; logic [3:0] wa3;
        logic pcs, regw, mtr, memw, alus;
        logic [2:0] aluc; logic [1:0] flagw;
    } dv_t;

    typedef struct packed {
        logic pcsrc, regw, memw, mtr, alus;
        logic [2:0] aluc; logic [3:0] wa3;
        logic condex; logic [3:0] flags;
    } ex_t;

    typedef struct { ex_t e; string name; } sb_t;

    sb_t q[$];
    int  n_chk = 0;
    int  n_fail = 0;

    idex_cond_stage #(.RESET_FLAGS(4'b0000)) dut (
        .clk(clk), .reset(reset), .StallE(StallE), .FlushE(FlushE),
        .CondD(CondD), .WA3D(WA3D), .PCSD(PCSD), .RegWD(RegWD),
        .MemtoRegD(MemtoRegD), .MemWD(MemWD), .ALUSrcD(ALUSrcD),
        .ALUControlD(ALUControlD), .FlagWD(FlagWD), .ALUFlags(ALUFlags),
        .PCSrcE(PCSrcE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
        .MemtoRegE(MemtoRegE), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
        .WA3E(WA3E), .CondExE(CondExE), .FlagsE(FlagsE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic dv_t mkd(input logic [3:0] cond, input int wa3, pcs, regw,
                                mtr, memw, alus, aluc, flagw);
        dv_t r;
        r.cond = cond; r.wa3 = wa3[3:0]; r.pcs = pcs[0]; r.regw = regw[0];
        r.mtr = mtr[0]; r.memw = memw[0]; r.alus = alus[0];
        r.aluc = aluc[2:0]; r.flagw = flagw[1:0];
        return r;
    endfunction

    function automatic ex_t mke(input int pcsrc, regw, memw, mtr, alus, aluc,
                                wa3, condex, flags);
        ex_t r;
        r.pcsrc = pcsrc[0]; r.regw = regw[0]; r.memw = memw[0]; r.mtr = mtr[0];
        r.alus = alus[0]; r.aluc = aluc[2:0]; r.wa3 = wa3[3:0];
        r.condex = condex[0]; r.flags = flags[3:0];
        return r;
    endfunction

    task automatic cyc(input string nm, input dv_t d, input logic [3:0] af,
                       input logic st, input logic fl, input logic rs, input ex_t e);
        sb_t s;
        CondD = d.cond; WA3D = d.wa3; PCSD = d.pcs; RegWD = d.regw;
        MemtoRegD = d.mtr; MemWD = d.memw; ALUSrcD = d.alus;
        ALUControlD = d.aluc; FlagWD = d.flagw;
        ALUFlags = af; StallE = st; FlushE = fl; reset = rs;
        @(posedge clk);
        #1;
        s.e = e; s.name = nm;
        q.push_back(s);
    endtask

    always @(negedge clk) begin
        sb_t  s;
        ex_t  a;
        if (q.size() > 0) begin
            s = q.pop_front();
            a = {PCSrcE, RegWriteE, MemWriteE, MemtoRegE, ALUSrcE,
                 ALUControlE, WA3E, CondExE, FlagsE};
            n_chk++;
            if (a !== s.e) begin
                n_fail++;
                $display("FAIL %s: got pc/rw/mw/mr/as=%b alu=%b wa3=%h cx=%b fl=%b, expected pc/rw/mw/mr/as=%b alu=%b wa3=%h cx=%b fl=%b",
                         s.name, a[16:12], a.aluc, a.wa3, a.condex, a.flags,
                         s.e[16:12], s.e.aluc, s.e.wa3, s.e.condex, s.e.flags);
            end
        end
    end

    initial begin
        dv_t nop, setf, s0;
        logic [15:0] gt_t, le_t;
        logic [3:0]  pf;
        nop  = mkd(C_AL, 0, 0, 0, 0, 0, 0, 0, 0);
        setf = mkd(C_AL, 1, 0, 1, 0, 0, 0, 4, 3);
        s0   = mkd(C_AL, 7, 0, 1, 1, 0, 0, 3, 3);
        gt_t = 16'h0A05;
        le_t = 16'hF5FA;

        // reset state
        cyc("reset0", nop, 4'h0, 0, 0, 1, mke(0,0,0,0,0,0,0,1,0));
        cyc("reset1", nop, 4'h0, 0, 0, 1, mke(0,0,0,0,0,0,0,1,0));

        // basic D->E transfer and CMP followed by EQ / NE store
        cyc("al_add", mkd(C_AL,5,0,1,0,0,0,0,0), 4'h0, 0,0,0, mke(0,1,0,0,0,0,5,1,0));
        cyc("cmp",    mkd(C_AL,0,0,0,0,0,1,1,3), 4'h0, 0,0,0, mke(0,0,0,0,1,1,0,1,0));
        cyc("str_eq", mkd(C_EQ,3,0,0,0,1,1,0,0), 4'b0100, 0,0,0, mke(0,0,1,0,1,0,3,1,4'b0100));
        cyc("cmp2",   mkd(C_AL,0,0,0,0,0,1,1,3), 4'h0, 0,0,0, mke(0,0,0,0,1,1,0,1,4'b0100));
        cyc("str_ne", mkd(C_NE,3,0,0,0,1,1,0,0), 4'b0100, 0,0,0, mke(0,0,0,0,1,0,3,0,4'b0100));

        // GT / LE / NV sweep over every NZCV value
        pf = 4'b0100;
        for (int v = 0; v < 16; v++) begin
            cyc($sformatf("set_%0d", v), setf, 4'h0, 0,0,0, mke(0,1,0,0,0,4,1,1,pf));
            cyc($sformatf("gt_%0d", v), mkd(C_GT,2,0,1,0,0,0,0,0), v[3:0], 0,0,0,
                mke(0, gt_t[v[3:0]], 0,0,0,0,2, gt_t[v[3:0]], v));
            cyc($sformatf("le_%0d", v), mkd(C_LE,2,0,1,0,0,0,0,0), 4'h0, 0,0,0,
                mke(0, le_t[v[3:0]], 0,0,0,0,2, le_t[v[3:0]], v));
            cyc($sformatf("nv_%0d", v), mkd(C_NV,2,0,1,0,0,0,0,0), 4'h0, 0,0,0,
                mke(0,0,0,0,0,0,2,0,v));
            pf = v[3:0];
        end

        // conditional branch LT, then a failing flag-setter
        cyc("set_n",   setf, 4'h0, 0,0,0, mke(0,1,0,0,0,4,1,1,4'hF));
        cyc("blt_tk",  mkd(C_LT,0,1,0,0,0,0,0,0), 4'b1000, 0,0,0, mke(1,0,0,0,0,0,0,1,4'b1000));
        cyc("set_nv",  setf, 4'h0, 0,0,0, mke(0,1,0,0,0,4,1,1,4'b1000));
        cyc("blt_nt",  mkd(C_LT,0,1,0,0,0,0,0,0), 4'b1001, 0,0,0, mke(0,0,0,0,0,0,0,0,4'b1001));
        cyc("subslt",  mkd(C_LT,4,0,1,0,0,0,1,3), 4'h0, 0,0,0, mke(0,0,0,0,0,1,4,0,4'b1001));
        cyc("no_flag", nop, 4'b0110, 0,0,0, mke(0,0,0,0,0,0,0,1,4'b1001));

        // stall holds E and flags; flush+stall gives bubble with frozen flags
        cyc("s0", s0, 4'h0, 0,0,0, mke(0,1,0,1,0,3,7,1,4'b1001));
        for (int i = 0; i < 3; i++)
            cyc($sformatf("stall_%0d", i), mkd(C_EQ,9,1,1,1,1,1,2,3), 4'b0110, 1,0,0,
                mke(0,1,0,1,0,3,7,1,4'b1001));
        cyc("flush_stall", mkd(C_EQ,9,1,1,1,1,1,2,3), 4'b0110, 1,1,0, mke(0,0,0,0,0,0,0,1,4'b1001));

        // flush alone still lets the leaving instruction write flags
        cyc("s0b",   s0, 4'h0, 0,0,0, mke(0,1,0,1,0,3,7,1,4'b1001));
        cyc("flush", nop, 4'b0110, 0,1,0, mke(0,0,0,0,0,0,0,1,4'b0110));

        // reset while a flag-setter is in E discards its update
        cyc("s0c",      s0, 4'h0, 0,0,0, mke(0,1,0,1,0,3,7,1,4'b0110));
        cyc("mid_rst",  s0, 4'hF, 0,0,1, mke(0,0,0,0,0,0,0,1,4'b0000));
        cyc("post_rst", nop, 4'h0, 0,0,0, mke(0,0,0,0,0,0,0,1,4'b0000));

        // independent NZ and CV write enables
        cyc("cv_w",  mkd(C_AL,0,0,0,0,0,0,0,1), 4'h0, 0,0,0, mke(0,0,0,0,0,0,0,1,4'b0000));
        cyc("cv_up", nop, 4'hF, 0,0,0, mke(0,0,0,0,0,0,0,1,4'b0011));
        cyc("nz_w",  mkd(C_AL,0,0,0,0,0,0,0,2), 4'hF, 0,0,0, mke(0,0,0,0,0,0,0,1,4'b0011));
        cyc("nz_up", nop, 4'b1101, 0,0,0, mke(0,0,0,0,0,0,0,1,4'b1111));

        repeat (2) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/idex_cond_stage.md
# idex_cond_stage

Pipeline stage between decode and execute. Each cycle it registers the decoder's control word (PCS, RegW, MemtoReg, MemW, ALUSrc, ALUControl, FlagW) together with the instruction's condition field and destination register. It holds the architectural NZCV flags register and evaluates the registered condition against it. It gates the write-type controls so that an instruction whose condition fails retires as a no-op.

## Interface
Parameters:
- RESET_FLAGS, 4'b0000, NZCV value loaded into the flags register on reset.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high.
- StallE  in  1  holds the E register and the flags register unchanged.
- FlushE  in  1  loads a bubble into the E register.
- CondD  in  4  instruction bits [31:28].
- WA3D  in  4  destination register (Rd).
- PCSD, RegWD, MemtoRegD, MemWD, ALUSrcD  in  1 each  decoder control.
- ALUControlD  in  3  decoder ALU select.
- FlagWD  in  2  decoder flag-write mask: [1] updates NZ, [0] updates CV.
- ALUFlags  in  4  {N,Z,C,V} from the execute-stage ALU, combinational from this stage's outputs.
- PCSrcE, RegWriteE, MemWriteE  out  1  control ANDed with CondExE.
- MemtoRegE, ALUSrcE  out  1  registered, ungated.
- ALUControlE  out  3  registered.
- WA3E  out  4  registered.
- CondExE  out  1  condition pass for the instruction currently in E.
- FlagsE  out  4  current flags register {N,Z,C,V}.

## Operation
- **E register load priority** (clock edge): reset, then FlushE, then StallE (hold), then load the D inputs.
- **Bubble / reset content:**
  - All control bits 0.
  - ALUControlE = 3'b000.
  - WA3E = 0.
  - CondE = 4'b1110 (AL).
- **Condition evaluation** (combinational from CondE and the flags register):
  - 0000 EQ Z; 0001 NE !Z.
  - 0010 CS C; 0011 CC !C.
  - 0100 MI N; 0101 PL !N.
  - 0110 VS V; 0111 VC !V.
  - 1000 HI C&!Z; 1001 LS !C|Z.
  - 1010 GE N==V; 1011 LT N!=V.
  - 1100 GT !Z&(N==V); 1101 LE Z|(N!=V).
  - 1110 AL 1.
  - 1111 0 (reserved; treated as never).
- **Gating:** PCSrcE = PCSE&CondExE; RegWriteE = RegWE&CondExE; MemWriteE = MemWE&CondExE.
- **Flags update** at the edge, when !reset and !StallE:
  - NZ ← ALUFlags[3:2] if FlagWE[1]&CondExE.
  - CV ← ALUFlags[1:0] if FlagWE[0]&CondExE.
  - Otherwise hold.
- FlushE does not block the flags update of the instruction leaving E that cycle; only StallE and reset block it.
- Reset in mid-operation: the E register becomes a bubble and flags become RESET_FLAGS in the same edge; any pending flag update is discarded.

## Timing
- D→E latency: 1 cycle.
- CondExE and the gated outputs are valid one cycle after capture, combinationally from registers; no ALUFlags→CondExE path.
- A flag-setting instruction in E at cycle t updates FlagsE at edge t+1. The next instruction, in E at t+1, evaluates against the new flags, so CMP followed immediately by a conditional instruction needs no stall.
- Under a sustained StallE, outputs are constant and flags are frozen.
- Simultaneous FlushE and StallE: flush wins.
- All outputs after reset:
  - PCSrcE, RegWriteE, MemWriteE, MemtoRegE, ALUSrcE = 0.
  - ALUControlE = 000; WA3E = 0.
  - CondExE = 1; FlagsE = RESET_FLAGS.

## Structure
- Shared package cpu_pkg holds:
  - cond_t enum (EQ…AL, NV);
  - flag index constants N=3, Z=2, C=1, V=0;
  - ALU control constants ADD=000, SUB=001, AND=010, ORR=011, MOV=100.
- Sub-module cond_check: purely combinational; inputs CondE and Flags; output CondExE. The E register, flags register and gating stay in idex_cond_stage.

## Test plan
- Reset, then AL ADD with RegWD=1, WA3D=5 → one cycle later RegWriteE=1, WA3E=5, ALUControlE=000, FlagsE=0000.
- CMP with FlagWD=11, ALUFlags=0100, next instruction EQ with MemWD=1 → FlagsE=0100 on the following cycle and MemWriteE=1; same sequence with NE → MemWriteE=0.
- GT/LE sweep over all 16 NZCV values, with each flags value preloaded via a flag-setting AL instruction → CondExE matches the table for every code; 1111 → 0.
- Conditional branch (PCSD=1, Cond=LT) with N=1, V=0 → PCSrcE=1; N=V=1 → PCSrcE=0, and a flag-setting instruction that fails its condition leaves FlagsE unchanged.
- StallE held 3 cycles with new D inputs and FlagWE=11 → E outputs and FlagsE unchanged; then FlushE and StallE together → bubble (all gated outputs 0, CondExE=1).
- Reset asserted while a flag-setting instruction is in E → next cycle FlagsE=RESET_FLAGS and all control outputs 0.
